// File: rtl/top_cpu_pkg.sv
// -----------------------------------------------------------------------------
// top_cpu_pkg
// Shared constants and types for the teaching-CPU datapath.
//   DATA_W    : operand / register width
//   NUM_REGS  : register file depth
//   RD_W      : width of the destination-register select
//   alu_op_e  : ALU operation encoding carried on f0
//   word_t    : one datapath word
// -----------------------------------------------------------------------------
package top_cpu_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam int RD_W     = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_AND = 2'b11
   } alu_op_e;

   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/top_cpu_alu.sv
// -----------------------------------------------------------------------------
// top_cpu_alu
// Purely combinational 16-bit ALU. All arithmetic wraps modulo 2^16; carry,
// borrow and the upper product half are dropped.
// Build option: TOP_CPU_MUL_EN -- when defined, f0=10 multiplies; when
// undefined, no multiplier is built and f0=10 produces zero.
// Ports:
//   f0     in  [1:0]   operation select (alu_op_e)
//   rs1    in  word_t  operand A (unsigned)
//   rs2    in  word_t  operand B (unsigned)
//   cin    in  1       carry-in, used by add only
//   bin    in  1       borrow-in, used by subtract only
//   result out word_t  ALU result
// -----------------------------------------------------------------------------
module top_cpu_alu
   import top_cpu_pkg::*;
(
   input  logic [1:0] f0,
   input  word_t      rs1,
   input  word_t      rs2,
   input  logic       cin,
   input  logic       bin,
   output word_t      result
);

   always_comb begin
      result = '0;
      case (alu_op_e'(f0))
         OP_ADD: result = rs1 + rs2 + word_t'(cin);
         OP_SUB: result = rs1 - rs2 - word_t'(bin);
`ifdef TOP_CPU_MUL_EN
         // Result context is 16 bits, so only the low product half is kept.
         OP_MUL: result = rs1 * rs2;
`else
         OP_MUL: result = '0;
`endif
         OP_AND: result = rs1 & rs2;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/top_cpu.sv
// -----------------------------------------------------------------------------
// top_cpu
// Single-cycle datapath: the ALU result is written every rising clk edge into
// the register selected by opcode_rd (no write enable). All registers are
// visible on out_wb. Register 0 is an ordinary writable register.
// Build option: TOP_CPU_MUL_EN enables the multiply operation (see ALU).
// Ports:
//   clk        in  1              rising-edge clock
//   rst_n      in  1              asynchronous active-low reset, clears regs
//   f0         in  [1:0]          ALU operation select
//   opcode_rd  in  [RD_W-1:0]     destination register index
//   rs1, rs2   in  word_t         operands
//   cin, bin   in  1              carry-in (add) / borrow-in (subtract)
//   out        out word_t         combinational ALU result
//   out_wb     out word_t [16]    register file contents, out_wb[i] = reg i
// -----------------------------------------------------------------------------
module top_cpu
   import top_cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      f0,
   input  logic [RD_W-1:0] opcode_rd,
   input  word_t           rs1,
   input  word_t           rs2,
   input  logic            cin,
   input  logic            bin,
   output word_t           out,
   output word_t           out_wb [NUM_REGS]
);

   word_t alu_res;

   top_cpu_alu u_alu (
      .f0     (f0),
      .rs1    (rs1),
      .rs2    (rs2),
      .cin    (cin),
      .bin    (bin),
      .result (alu_res)
   );

   assign out = alu_res;

   // Each register is its own flop bank so the asynchronous clear reaches
   // every entry; the destination decode is a simple per-register compare.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         word_t reg_q;
         word_t reg_d;

         always_comb begin
            reg_d = reg_q;
            if (opcode_rd == RD_W'(gi)) begin
               reg_d = alu_res;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reg_q <= '0;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign out_wb[gi] = reg_q;
      end
   endgenerate

endmodule

// File: tb/tb_top_cpu.sv
// -----------------------------------------------------------------------------
// tb_top_cpu
// Directed vectors with hand-computed results. The stimulus process pushes the
// expected ALU output and the expected full register file for each write into
// a queue; a monitor pops one entry 1 ns after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_top_cpu;

   logic        clk;
   logic        rst_n;
   logic [1:0]  f0;
   logic [3:0]  opcode_rd;
   logic [15:0] rs1;
   logic [15:0] rs2;
   logic        cin;
   logic        bin;
   logic [15:0] out;
   logic [15:0] out_wb [16];

   typedef struct packed {
      logic [15:0]       exp_out;
      logic [15:0][15:0] exp_regs;
   } sb_item_t;

   sb_item_t          sb_q[$];
   logic [15:0][15:0] model_regs;
   int                n_checks;
   int                n_pass;

`ifdef TOP_CPU_MUL_EN
   localparam logic [15:0] MUL_EXP = 16'h5F90;
`else
   localparam logic [15:0] MUL_EXP = 16'h0000;
`endif

   top_cpu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .f0        (f0),
      .opcode_rd (opcode_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .cin       (cin),
      .bin       (bin),
      .out       (out),
      .out_wb    (out_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare the whole register file against an expected image.
   task automatic check_regs(input string name, input logic [15:0][15:0] exp);
      int bad;
      bad = -1;
      for (int i = 15; i >= 0; i--) begin
         if (out_wb[i] !== exp[i]) bad = i;
      end
      n_checks++;
      if (bad < 0) begin
         n_pass++;
      end else begin
         $display("FAIL %s: out_wb[%0d] actual=%h required=%h", name, bad,
                  out_wb[bad], exp[bad]);
      end
   endtask

   // Monitor: one scoreboard entry per written edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            n_checks++;
            if (out === it.exp_out) begin
               n_pass++;
            end else begin
               $display("FAIL alu_out: actual=%h required=%h", out, it.exp_out);
            end
            check_regs("regfile", it.exp_regs);
            $display("txn: out=%h rd-written result checked, regs checked", out);
         end
      end
   end

   // Drive one write while clk is low, record the expectation, step one edge.
   task automatic do_write(input logic [1:0] op, input logic [3:0] rd,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic bi,
                           input logic [15:0] exp);
      sb_item_t it;
      f0        = op;
      opcode_rd = rd;
      rs1       = a;
      rs2       = b;
      cin       = ci;
      bin       = bi;
      model_regs[rd] = exp;
      it.exp_out  = exp;
      it.exp_regs = model_regs;
      sb_q.push_back(it);
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      model_regs = '0;
      rst_n      = 1'b0;
      f0         = 2'b00;
      opcode_rd  = 4'd5;
      rs1        = 16'd9;
      rs2        = 16'd9;
      cin        = 1'b0;
      bin        = 1'b0;

      // Reset held for two edges with a live write pending: nothing lands.
      repeat (2) @(posedge clk);
      #2;
      check_regs("reset_state", model_regs);
      rst_n = 1'b1;

      do_write(2'b00, 4'd3,  16'd120,  16'd10,   1'b0, 1'b0, 16'd130);
      do_write(2'b00, 4'd3,  16'd120,  16'd10,   1'b1, 1'b0, 16'd131);
      do_write(2'b01, 4'd7,  16'd5,    16'd10,   1'b0, 1'b1, 16'hFFFA);
      do_write(2'b01, 4'd8,  16'd120,  16'd10,   1'b0, 1'b0, 16'd110);
      do_write(2'b10, 4'd15, 16'd300,  16'd300,  1'b1, 1'b1, MUL_EXP);
      do_write(2'b11, 4'd0,  16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000);
      do_write(2'b00, 4'd1,  16'd0,    16'd1,    1'b0, 1'b0, 16'd1);
      // cin ignored by subtract, bin ignored by add and AND
      do_write(2'b01, 4'd4,  16'd20,   16'd3,    1'b1, 1'b0, 16'd17);
      do_write(2'b00, 4'd5,  16'd1,    16'd1,    1'b0, 1'b1, 16'd2);
      do_write(2'b11, 4'd9,  16'hFFFF, 16'h1234, 1'b1, 1'b1, 16'h1234);
      // add wraps past 16 bits
      do_write(2'b00, 4'd10, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001);
      // back-to-back overwrite of the same register
      do_write(2'b00, 4'd3,  16'd120,  16'd10,   1'b0, 1'b0, 16'd130);
      do_write(2'b00, 4'd3,  16'd40,   16'd2,    1'b0, 1'b0, 16'd42);

      // Asynchronous clear mid-cycle, away from any clock edge.
      rst_n = 1'b0;
      model_regs = '0;
      #1;
      check_regs("async_reset", model_regs);
      // A pending write across an edge while in reset must not land.
      f0 = 2'b00; opcode_rd = 4'd6; rs1 = 16'd3; rs2 = 16'd4; cin = 1'b0;
      @(posedge clk);
      #2;
      check_regs("no_write_in_reset", model_regs);
      rst_n = 1'b1;
      do_write(2'b00, 4'd2,  16'd7,    16'd8,    1'b0, 1'b0, 16'd15);

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
      #3;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL sb_drain: pending=%0d required=0", sb_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/top_cpu.md
# top_cpu

Minimal single-cycle datapath: a 16-bit ALU whose result is written each clock into one of sixteen 16-bit registers chosen by a 4-bit destination select, with all registers exposed for observation. It is the top of the teaching CPU and has no instruction fetch; operands and control come from ports.

## Interface
- DATA_W, 16, operand/register width
- NUM_REGS, 16, register count; the destination select is log2(NUM_REGS) bits wide
- clk  input  1  sole clock; rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- f0  input  2  ALU operation select
- opcode_rd  input  4  destination register index (demux select)
- rs1  input  16  operand A
- rs2  input  16  operand B
- cin  input  1  carry-in for add
- bin  input  1  borrow-in for subtract
- out  output  16  combinational ALU result
- out_wb  output  16 x [16]  unpacked array of all register contents; out_wb[i] is register i

## Operation
- ALU result, all arithmetic modulo 2^16; carry/borrow-out and upper product bits are discarded:
  - f0=00: rs1 + rs2 + cin
  - f0=01: rs1 − rs2 − bin
  - f0=10: low 16 bits of rs1 × rs2 (unsigned)
  - f0=11: rs1 & rs2
- cin is ignored for f0≠00; bin is ignored for f0≠01.
- Operands are unsigned.
- Every rising clk edge with rst_n high writes the ALU result into register[opcode_rd]. There is no write enable.
- All 16 registers are writable; register 0 is not hardwired to zero.
- Unselected registers hold their value.
- out_wb is a direct view of the register array.

## Timing
- out follows the inputs combinationally in the same cycle.
- Write latency is 1 cycle: the value appears on out_wb[opcode_rd] after the first rising edge at which the inputs are stable.
- rst_n low asynchronously clears all registers to 0, so every out_wb[i] = 0. out remains combinational and is unaffected by reset.
- While rst_n is low, no write occurs. The first write happens at the first rising edge after rst_n deasserts.
- Reset asserted mid-run clears all registers immediately, regardless of clk.
- Rewriting the same register on consecutive edges overwrites it; the last write wins.

## Configuration
- TOP_CPU_MUL_EN defined: f0=10 performs the multiply.
- TOP_CPU_MUL_EN undefined: the multiplier is not synthesised, f0=10 yields 16'h0000, and the write still occurs.

## Structure
- Package top_cpu_pkg holds:
  - DATA_W and NUM_REGS constants
  - typedef enum logic [1:0] alu_op_e {OP_ADD, OP_SUB, OP_MUL, OP_AND}
  - typedef logic [15:0] word_t
- One sub-module, top_cpu_alu: purely combinational, taking (f0, rs1, rs2, cin, bin) and producing the result.
- The register array and write demux live in top_cpu.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> all out_wb[i]=0. Assert rst_n=0 mid-run asynchronously -> all registers clear without a clock edge.
- Add: rs1=120, rs2=10, cin=0, f0=00, opcode_rd=3, one edge -> out=130, out_wb[3]=130, all other registers 0. Repeat with cin=1 -> out_wb[3]=131.
- Subtract with wrap: rs1=5, rs2=10, bin=1, f0=01, rd=7 -> out_wb[7]=16'hFFFA. Also rs1=120, rs2=10, bin=0 -> 110.
- Multiply truncation: rs1=300, rs2=300, f0=10, rd=15 -> out_wb[15]=16'h5F90 (90000 mod 65536 = 24464) with TOP_CPU_MUL_EN defined; 0 without it.
- AND and register independence: rs1=16'hF0F0, rs2=16'hFF00, f0=11, rd=0 -> out_wb[0]=16'hF000. Then write 1 into rd=1 -> out_wb[0] unchanged.
- Overwrite: write 130 to rd=3, then 42 to rd=3 on the next edge -> out_wb[3]=42 one cycle after the second write.
